// File: rtl/argmax_pkg.sv
// Shared definitions for the arg-max classifier.
//   state_e    : scan controller states (idle, scanning, result held)
//   idx_width  : width of a class index for a given class count
//   min_score  : most negative value of a signed score of a given width
package argmax_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  // Never narrower than one bit, even for two classes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // -2^(w-1), returned in 32 bits; callers truncate to their score width.
  function automatic logic signed [31:0] min_score(input int unsigned w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational update unit for one arg-max scan step.
// Configuration: ARGMAX_MARGIN_EN adds the second-best tracking path.
// Ports:
//   best, best_idx    : running best score and its class index
//   second            : running second-best score (ARGMAX_MARGIN_EN only)
//   cand, cand_idx    : candidate score and its class index
//   best_next         : updated best score
//   second_next       : updated second-best score (ARGMAX_MARGIN_EN only)
//   idx_next          : updated best index
module argmax_cmp
  import argmax_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic signed [W-1:0]     best,
  input  logic [IDX_W-1:0]        best_idx,
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [W-1:0]     second,
  output logic signed [W-1:0]     second_next,
`endif
  input  logic signed [W-1:0]     cand,
  input  logic [IDX_W-1:0]        cand_idx,
  output logic signed [W-1:0]     best_next,
  output logic [IDX_W-1:0]        idx_next
);

  logic replace;

  // Strict compare: on a tie the earlier (lower) index is kept.
  assign replace = cand > best;

  always_comb begin
    best_next = best;
    idx_next  = best_idx;
    if (replace) begin
      best_next = cand;
      idx_next  = cand_idx;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  // A tie with best counts as a second best so the margin becomes zero.
  always_comb begin
    second_next = second;
    if (replace) begin
      second_next = best;
    end else if ((cand > second) || (cand == best)) begin
      second_next = cand;
    end
  end
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Sequential arg-max over NUM_CLASSES signed scores, one element per cycle.
// Configuration: define ARGMAX_MARGIN_EN to report best - second-best on
// margin; otherwise margin is tied to 0.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start           : capture in_vector_flat and begin a scan (IDLE/DONE only)
//   in_vector_flat  : class k score in bits [k*W +: W]
//   class_idx       : winning class index (registered)
//   class_score     : winning class score (registered)
//   margin          : unsigned best - second best, W+1 bits (registered)
//   busy            : scan in progress
//   done            : result valid, held until next accepted start or reset
module argmax_classifier
  import argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned W           = 8,
  parameter int unsigned IDX_W       = idx_width(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [W*NUM_CLASSES-1:0] in_vector_flat,
  output logic [IDX_W-1:0]         class_idx,
  output logic signed [W-1:0]      class_score,
  output logic [W:0]               margin,
  output logic                     busy,
  output logic                     done
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

  state_e                     state_q;
  logic [W*NUM_CLASSES-1:0]   vec_q;
  logic [IDX_W-1:0]           cnt_q;
  logic signed [W-1:0]        best_q;
  logic [IDX_W-1:0]           best_idx_q;
  logic signed [W-1:0]        cand;
  logic signed [W-1:0]        best_nxt;
  logic [IDX_W-1:0]           idx_nxt;

  assign cand = vec_q[int'(cnt_q) * W +: W];

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [W-1:0] MinScore = W'(min_score(W));

  logic signed [W-1:0] second_q;
  logic signed [W-1:0] second_nxt;
  logic [W:0]          margin_calc;

  // Sign-extend so the difference of any two W-bit scores fits without wrap.
  assign margin_calc = {best_nxt[W-1], best_nxt} - {second_nxt[W-1], second_nxt};
`else
  assign margin = '0;
`endif

  argmax_cmp #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .best        (best_q),
    .best_idx    (best_idx_q),
`ifdef ARGMAX_MARGIN_EN
    .second      (second_q),
    .second_next (second_nxt),
`endif
    .cand        (cand),
    .cand_idx    (cnt_q),
    .best_next   (best_nxt),
    .idx_next    (idx_nxt)
  );

  // The captured vector is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_idx   <= '0;
      class_score <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_q    <= '0;
      margin      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            vec_q      <= in_vector_flat;
            best_q     <= in_vector_flat[W-1:0];
            best_idx_q <= '0;
            cnt_q      <= IDX_W'(1);
            busy       <= 1'b1;
            done       <= 1'b0;
            state_q    <= StScan;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= MinScore;
`endif
          end
        end
        StScan: begin
          best_q     <= best_nxt;
          best_idx_q <= idx_nxt;
          cnt_q      <= cnt_q + 1'b1;
`ifdef ARGMAX_MARGIN_EN
          second_q   <= second_nxt;
`endif
          if (cnt_q == LastIdx) begin
            class_idx   <= idx_nxt;
            class_score <= best_nxt;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_q     <= StDone;
`ifdef ARGMAX_MARGIN_EN
            margin      <= margin_calc;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: stimulus pushes reference results,
// a negedge monitor pops and checks them whenever done rises.
module tb_argmax_classifier;

  localparam int N     = 10;
  localparam int W     = 8;
  localparam int IDX_W = 4;

  typedef struct {
    int idx;
    int score;
    int margin;
    int issue;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [W*N-1:0]   in_vec = '0;
  logic [IDX_W-1:0] class_idx;
  logic signed [W-1:0] class_score;
  logic [W:0]       margin;
  logic             busy;
  logic             done;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic done_prev = 1'b0;
  exp_t sb[$];

  argmax_classifier #(
    .NUM_CLASSES (N),
    .W           (W),
    .IDX_W       (IDX_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .in_vector_flat (in_vec),
    .class_idx      (class_idx),
    .class_score    (class_score),
    .margin         (margin),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: winner is the first maximum; margin is the maximum minus the
  // largest of the remaining elements (a duplicate maximum gives zero).
  function automatic exp_t model(input int s[N]);
    exp_t e;
    int   bi = 0;
    int   sec = -1000;
    for (int k = 1; k < N; k++) if (s[k] > s[bi]) bi = k;
    for (int k = 0; k < N; k++) if (k != bi && s[k] > sec) sec = s[k];
    e.idx   = bi;
    e.score = s[bi];
`ifdef ARGMAX_MARGIN_EN
    e.margin = s[bi] - sec;
`else
    e.margin = 0;
`endif
    e.issue = 0;
    return e;
  endfunction

  task automatic set_vec(input int s[N]);
    for (int k = 0; k < N; k++) in_vec[k*W +: W] = 8'(s[k]);
  endtask

  // Called just before the edge that accepts start.
  task automatic push_exp(input int s[N]);
    exp_t e;
    e = model(s);
    e.issue = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic pulse_start(input int s[N]);
    @(negedge clk);
    set_vec(s);
    start = 1'b1;
    push_exp(s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_idx"},    int'(class_idx), 0);
    check({tag, "_score"},  int'(class_score), 0);
    check({tag, "_margin"}, int'(margin), 0);
    check({tag, "_busy"},   int'(busy), 0);
    check({tag, "_done"},   int'(done), 0);
  endtask

  // Monitor: compare on every rising edge of done; busy/done exclusive always.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy_done_excl", int'(busy && done), 0);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("class_idx",   int'(class_idx), e.idx);
          check("class_score", int'(class_score), e.score);
          check("margin",      int'(margin), e.margin);
          check("latency",     cyc - e.issue, N - 1);
        end
      end
    end
    done_prev <= done;
  end

  initial begin
    int v[N];
    int b[N];

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Single winner.
    foreach (v[k]) v[k] = 5;
    v[7] = 100;
    pulse_start(v);
    repeat (12) @(negedge clk);

    // Tie keeps the lower index.
    foreach (v[k]) v[k] = 0;
    v[2] = 127; v[5] = 127;
    pulse_start(v);
    repeat (12) @(negedge clk);

    // Signed compare.
    foreach (v[k]) v[k] = -128;
    v[9] = -1;
    pulse_start(v);
    repeat (12) @(negedge clk);

    foreach (v[k]) v[k] = 0;
    pulse_start(v);
    repeat (12) @(negedge clk);

    // Start while done is held: done drops at the accepting edge.
    foreach (v[k]) v[k] = k * 3 - 10;
    pulse_start(v);
    check("restart_done_low", int'(done), 0);
    check("restart_busy_high", int'(busy), 1);
    repeat (12) @(negedge clk);

    // Start re-pulsed mid-scan with another vector is ignored.
    foreach (v[k]) v[k] = 0;
    v[4] = 60;
    foreach (b[k]) b[k] = 0;
    b[8] = 90;
    pulse_start(v);
    repeat (2) @(negedge clk);
    set_vec(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Mid-scan reset.
    foreach (v[k]) v[k] = 0;
    v[1] = 77;
    pulse_start(v);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midscan_reset");
    sb.delete();
    reset = 1'b0;
    foreach (v[k]) v[k] = 0;
    v[3] = 50;
    pulse_start(v);
    repeat (12) @(negedge clk);

    // Start held high: back-to-back classifications every N cycles.
    @(negedge clk);
    foreach (v[k]) v[k] = $urandom_range(0, 255) - 128;
    set_vec(v);
    start = 1'b1;
    push_exp(v);
    for (int r = 0; r < 3; r++) begin
      repeat (N) @(negedge clk);
      check("held_done_high", int'(done), 1);
      foreach (v[k]) v[k] = $urandom_range(0, 255) - 128;
      set_vec(v);
      push_exp(v);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Random vectors; narrow ranges make ties likely.
    for (int t = 0; t < 40; t++) begin
      if (t % 3 == 0) foreach (v[k]) v[k] = $urandom_range(0, 3) - 2;
      else            foreach (v[k]) v[k] = $urandom_range(0, 255) - 128;
      pulse_start(v);
      repeat (N + $urandom_range(0, 3)) @(negedge clk);
    end

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
